elevator_movement: RTL and testbench

- Movement controller for a three-floor elevator car.
- Latches hall/car call buttons into pending requests and drives one request LED per floor.
- Moves the car one floor at a time, opens the door on arrival and shows the current floor one-hot.
- Sits between the debounced push-button/LED panel and the floor display and door driver.

---
 rtl/elevator_movement_if.sv | 29 ++
 rtl/elevator_movement.sv | 188 ++++++++++++++++++
 tb/tb_elevator_movement.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/elevator_movement_if.sv
// Panel/display bundle for the elevator movement controller.
// master = panel/test side, slave = controller side.
interface elevator_movement_if;
    logic button1;
    logic button2;
    logic button3;
    logic led1;
    logic led2;
    logic led3;
    logic floor1;
    logic floor2;
    logic floor3;
    logic door;
    logic moving;

    modport master (
        output button1, button2, button3,
        input  led1, led2, led3,
        input  floor1, floor2, floor3,
        input  door, moving
    );

    modport slave (
        input  button1, button2, button3,
        output led1, led2, led3,
        output floor1, floor2, floor3,
        output door, moving
    );
endinterface

// File: rtl/elevator_movement.sv
// Three-floor elevator movement controller: latches calls, sweeps floors, opens door.
// Optional macro BUTTON_SYNC_EN adds a two-flop synchronizer on each button.
module elevator_movement #(
    parameter int FLOOR_TICKS = 4,
    parameter int DOOR_TICKS  = 4
) (
    input  logic             clk,
    input  logic             rst,
    elevator_movement_if.slave bus
);

    localparam int CW = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE,
        S_DOOR
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    floor_q, floor_d;
    logic          dir_q, dir_d;
    logic [2:0]    req_q, req_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [2:0] raw_btn;
    logic [2:0] smp_q;
    logic [2:0] prev_q;
    logic [2:0] press;
    logic [2:0] cur_oh;
    logic [2:0] nxt_oh;
    logic [1:0] nxt;
    logic [2:0] set_req;
    logic [2:0] clr_req;
    logic       stopped;
    logic       here_press;

    assign raw_btn = {bus.button3, bus.button2, bus.button1};

`ifdef BUTTON_SYNC_EN
    logic [2:0] meta_q;

    // Two-flop synchronizer ahead of the edge detector (buttons are active-low).
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 3'b111;
            smp_q  <= 3'b111;
        end else begin
            meta_q <= raw_btn;
            smp_q  <= meta_q;
        end
    end
`else
    // Single sampling register ahead of the edge detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            smp_q <= 3'b111;
        end else begin
            smp_q <= raw_btn;
        end
    end
`endif

    // Previous sample for 1->0 press detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 3'b111;
        end else begin
            prev_q <= smp_q;
        end
    end

    assign press      = prev_q & ~smp_q;
    assign cur_oh     = 3'b001 << floor_q;
    assign stopped    = (state_q != S_MOVE);
    assign here_press = stopped && ((press & cur_oh) != 3'b000);
    assign set_req    = press & ~(stopped ? cur_oh : 3'b000);

    // Keep direction if a request lies that way, else reverse; ends force it.
    function automatic logic pick_dir(
        input logic [1:0] f,
        input logic       up,
        input logic [2:0] req
    );
        logic above;
        logic below;
        above = (f == 2'd0) ? |req[2:1] :
                (f == 2'd1) ? req[2] : 1'b0;
        below = (f == 2'd2) ? |req[1:0] :
                (f == 2'd1) ? req[0] : 1'b0;
        if (f == 2'd2) begin
            return 1'b0;
        end else if (f == 2'd0) begin
            return 1'b1;
        end else if (up) begin
            return above;
        end else begin
            return !below;
        end
    endfunction

    assign nxt = dir_q ? ((floor_q == 2'd2) ? 2'd2 : floor_q + 2'd1)
                       : ((floor_q == 2'd0) ? 2'd0 : floor_q - 2'd1);
    assign nxt_oh = 3'b001 << nxt;

    // Next-state logic: request bookkeeping, travel and door timing.
    always_comb begin
        state_d = state_q;
        floor_d = floor_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        clr_req = 3'b000;
        unique case (state_q)
            S_IDLE: begin
                if (here_press) begin
                    state_d = S_DOOR;
                    cnt_d   = CW'(DOOR_TICKS);
                end else if ((req_q & cur_oh) != 3'b000) begin
                    clr_req = cur_oh;
                    state_d = S_DOOR;
                    cnt_d   = CW'(DOOR_TICKS);
                end else if (req_q != 3'b000) begin
                    dir_d   = pick_dir(floor_q, dir_q, req_q);
                    state_d = S_MOVE;
                    cnt_d   = CW'(FLOOR_TICKS);
                end
            end
            S_MOVE: begin
                if (cnt_q > CW'(1)) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    floor_d = nxt;
                    if ((req_q & nxt_oh) != 3'b000) begin
                        clr_req = nxt_oh;
                        state_d = S_DOOR;
                        cnt_d   = CW'(DOOR_TICKS);
                        dir_d   = (nxt == 2'd2) ? 1'b0 :
                                  (nxt == 2'd0) ? 1'b1 : dir_q;
                    end else begin
                        cnt_d = CW'(FLOOR_TICKS);
                        dir_d = pick_dir(nxt, dir_q, req_q);
                    end
                end
            end
            S_DOOR: begin
                if (here_press) begin
                    cnt_d = CW'(DOOR_TICKS);
                end else if (cnt_q > CW'(1)) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        req_d = (req_q | set_req) & ~clr_req;
    end

    // State, position, direction, request and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            floor_q <= 2'd0;
            dir_q   <= 1'b1;
            req_q   <= 3'b000;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            floor_q <= floor_d;
            dir_q   <= dir_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.led1   = req_q[0];
    assign bus.led2   = req_q[1];
    assign bus.led3   = req_q[2];
    assign bus.floor1 = (floor_q == 2'd0);
    assign bus.floor2 = (floor_q == 2'd1);
    assign bus.floor3 = (floor_q == 2'd2);
    assign bus.door   = (state_q == S_DOOR);
    assign bus.moving = (state_q == S_MOVE);

endmodule

// File: tb/tb_elevator_movement.sv
// Bench for elevator_movement: directed scenarios plus random call sets
// checked against a sweep-order reference model.
module tb_elevator_movement;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    elevator_movement_if ifc();

    elevator_movement #(
        .FLOOR_TICKS(4),
        .DOOR_TICKS (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.slave)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int fl();
        return int'({ifc.floor3, ifc.floor2, ifc.floor1});
    endfunction

    function automatic int ld();
        return int'({ifc.led3, ifc.led2, ifc.led1});
    endfunction

    function automatic int fidx();
        return ifc.floor3 ? 3 : (ifc.floor2 ? 2 : 1);
    endfunction

    task automatic set_btn(input logic [2:0] low_mask);
        ifc.button1 = ~low_mask[0];
        ifc.button2 = ~low_mask[1];
        ifc.button3 = ~low_mask[2];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_btn(3'b000);
        step(2);
        rst = 1'b0;
    endtask

    // One-cycle press of the floors in mask; returns at the negedge
    // after the second edge (request latch point).
    task automatic press(input logic [2:0] mask);
        set_btn(mask);
        step(1);
        set_btn(3'b000);
        step(1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          mf;
        bit          mup;
        int          rises;
        logic [2:0]  mask;
        logic [2:0]  m;
        int          cur;
        int          expv[$];
        int          got[$];
        bit          prev_door;
        bit          done;

        rst = 1'b0;
        set_btn(3'b000);

        // Reset state
        do_reset();
        check("rst_floor", fl(), 1);
        check("rst_led", ld(), 0);
        check("rst_door", int'(ifc.door), 0);
        check("rst_moving", int'(ifc.moving), 0);

        // Floor 1 -> 2 single trip with exact timing
        press(3'b010);
        check("t2_led", ld(), 2);
        check("t2_idle", int'(ifc.moving), 0);
        step(1);
        check("t2_move", int'(ifc.moving), 1);
        check("t2_dep", fl(), 1);
        step(3);
        check("t2_still", int'(ifc.moving), 1);
        check("t2_still_fl", fl(), 1);
        step(1);
        check("t2_arr_fl", fl(), 2);
        check("t2_arr_led", ld(), 0);
        check("t2_arr_door", int'(ifc.door), 1);
        check("t2_arr_mov", int'(ifc.moving), 0);
        step(3);
        check("t2_door_hold", int'(ifc.door), 1);
        step(1);
        check("t2_door_shut", int'(ifc.door), 0);
        check("t2_idle2", int'(ifc.moving), 0);

        // Press for the current floor while idle
        do_reset();
        press(3'b001);
        check("cur_led", ld(), 0);
        check("cur_door", int'(ifc.door), 1);
        step(3);
        check("cur_door_hold", int'(ifc.door), 1);
        step(1);
        check("cur_door_shut", int'(ifc.door), 0);
        step(5);
        check("cur_nomove", int'(ifc.moving), 0);
        check("cur_floor", fl(), 1);

        // Floor 3 call, floor 2 call added while moving
        do_reset();
        press(3'b100);
        check("sw_led3", ld(), 4);
        step(1);
        check("sw_move", int'(ifc.moving), 1);
        set_btn(3'b010);
        step(1);
        set_btn(3'b000);
        step(1);
        check("sw_led23", ld(), 6);
        step(2);
        check("sw_stop2", fl(), 2);
        check("sw_stop2_door", int'(ifc.door), 1);
        check("sw_stop2_led", ld(), 4);
        step(4);
        check("sw_shut2", int'(ifc.door), 0);
        step(1);
        check("sw_move2", int'(ifc.moving), 1);
        step(4);
        check("sw_arr3", fl(), 4);
        check("sw_arr3_door", int'(ifc.door), 1);
        check("sw_arr3_led", ld(), 0);

        // Button held low for 20 cycles gives exactly one trip
        do_reset();
        rises = 0;
        prev_door = 1'b0;
        set_btn(3'b100);
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (ifc.door && !prev_door) rises++;
            prev_door = ifc.door;
        end
        check("hold_floor", fl(), 4);
        check("hold_led", ld(), 0);
        set_btn(3'b000);
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (ifc.door && !prev_door) rises++;
            prev_door = ifc.door;
        end
        check("hold_stops", rises, 1);
        check("hold_led2", ld(), 0);
        check("hold_moving", int'(ifc.moving), 0);

        // Reset while travelling between floors 1 and 2
        do_reset();
        press(3'b010);
        step(2);
        check("mrst_moving", int'(ifc.moving), 1);
        rst = 1'b1;
        step(1);
        check("mrst_floor", fl(), 1);
        check("mrst_moving0", int'(ifc.moving), 0);
        check("mrst_door", int'(ifc.door), 0);
        check("mrst_led", ld(), 0);
        rst = 1'b0;

        // Random call sets against a sweep-order model
        do_reset();
        mf = 1;
        mup = 1'b1;
        for (int t = 0; t < 14; t++) begin
            mask = 3'($urandom_range(1, 7));
            m = mask;
            cur = mf;
            expv.delete();
            got.delete();
            if (m[cur-1]) begin
                expv.push_back(cur);
                m[cur-1] = 1'b0;
            end
            while (m != 3'b000) begin
                bit above;
                bit below;
                above = 1'b0;
                below = 1'b0;
                for (int f = 1; f <= 3; f++) begin
                    if (m[f-1] && f > cur) above = 1'b1;
                    if (m[f-1] && f < cur) below = 1'b1;
                end
                if (mup && !above) mup = 1'b0;
                else if (!mup && !below) mup = 1'b1;
                cur = mup ? cur + 1 : cur - 1;
                while (!m[cur-1]) cur = mup ? cur + 1 : cur - 1;
                expv.push_back(cur);
                m[cur-1] = 1'b0;
            end
            if (cur == 3) mup = 1'b0;
            if (cur == 1) mup = 1'b1;

            press(mask);
            check("rnd_led", ld(),
                  int'(mask & ~(3'b001 << (mf - 1))));
            prev_door = 1'b0;
            done = 1'b0;
            for (int c = 0; c < 200 && !done; c++) begin
                if (ifc.door && !prev_door) got.push_back(fidx());
                prev_door = ifc.door;
                checks++;
                assert ($countones({ifc.floor3, ifc.floor2, ifc.floor1}) == 1
                        && !(ifc.door && ifc.moving)) else begin
                    failures++;
                    $error("FAIL rnd_invariant observed=%0d expected=onehot",
                           fl());
                end
                if (!ifc.door && !ifc.moving && ld() == 0) done = 1'b1;
                else step(1);
            end
            check("rnd_done", int'(done), 1);
            check("rnd_nstops", got.size(), expv.size());
            for (int k = 0; k < expv.size() && k < got.size(); k++) begin
                check("rnd_stop", got[k], expv[k]);
            end
            check("rnd_final", fidx(), cur);
            mf = cur;
            step($urandom_range(1, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
